// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of the single shared-memory port.
//
// Each proc requests with i_req_rd or i_req_wr and waits for its own grant.
// A grant is kept while its owner keeps requesting the same access type. When
// another proc is also waiting, the owner is preempted after MAX_HOLD granted
// cycles. The owner's address, write data and write size are muxed onto the
// memory port.
//
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_req_rd / i_req_wr      per-proc read / write requests
//   i_addr, i_wdata, i_wsize per-proc payload, proc k in slice k
//   o_grant_rd / o_grant_wr  registered grants, at most one bit set in total
//   o_mem_re / o_mem_we      memory enables, decoded from the grants
//   o_mem_addr/wdata/wsize   owner's payload, 0 when idle
//   o_owner, o_busy          current owner index, grant active
module mem_arbiter #(
    parameter int unsigned N_PROC   = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned BUS_W    = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [N_PROC-1:0]           i_req_rd,
    input  logic [N_PROC-1:0]           i_req_wr,
    input  logic [N_PROC*ADDR_W-1:0]    i_addr,
    input  logic [N_PROC*BUS_W-1:0]     i_wdata,
    input  logic [N_PROC*3-1:0]         i_wsize,
    output logic [N_PROC-1:0]           o_grant_rd,
    output logic [N_PROC-1:0]           o_grant_wr,
    output logic                        o_mem_re,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [BUS_W-1:0]            o_mem_wdata,
    output logic [2:0]                  o_mem_wsize,
    output logic [$clog2(N_PROC)-1:0]   o_owner,
    output logic                        o_busy
);

    localparam int unsigned IDX_W  = $clog2(N_PROC);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_PROC - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] OWN_RD = 2'd1;
    localparam logic [1:0] OWN_WR = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_PROC-1:0] grant_rd_d, grant_wr_d;

    logic [N_PROC-1:0] req;
    logic [N_PROC-1:0] own_mask;
    logic [N_PROC-1:0] others;
    logic [N_PROC-1:0] cand;
    logic              cur_req;
    logic              do_arb;
    logic [IDX_W:0]    pick_res;
    logic              found;
    logic [IDX_W-1:0]  win;

    // First set bit of cand at or after start, wrapping; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_PROC-1:0] c,
                                               input logic [IDX_W-1:0]  start);
        logic [IDX_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned i = 0; i < N_PROC; i++) begin
            idx = 32'(start) + i;
            if (idx >= N_PROC) begin
                idx = idx - N_PROC;
            end
            if (!res[IDX_W] && c[IDX_W'(idx)]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    assign req      = i_req_rd | i_req_wr;
    assign own_mask = N_PROC'(1) << o_owner;
    assign others   = req & ~own_mask;
    assign cur_req  = (state_q == OWN_WR) ? i_req_wr[o_owner] : i_req_rd[o_owner];

    // State register plus registered grants, owner, pointer and hold count.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_q     <= '0;
            o_owner    <= '0;
            o_grant_rd <= '0;
            o_grant_wr <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            o_owner    <= owner_d;
            o_grant_rd <= grant_rd_d;
            o_grant_wr <= grant_wr_d;
        end
    end

    // Keep / release / preempt decision and round-robin re-arbitration.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        owner_d    = o_owner;
        do_arb     = 1'b0;
        cand       = req;

        case (state_q)
            IDLE: begin
                do_arb = |req;
            end
            OWN_RD, OWN_WR: begin
                if (!cur_req) begin
                    // Release: the owner may win again with its other type.
                    do_arb = 1'b1;
                end else if ((hold_q == HOLD_LAST) && (|others)) begin
                    do_arb = 1'b1;
                    cand   = others;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pick_res = rr_pick(cand, ptr_q);
        found    = pick_res[IDX_W];
        win      = pick_res[IDX_W-1:0];

        if (do_arb) begin
            if (found) begin
                owner_d = win;
                ptr_d   = (win == IDX_LAST) ? '0 : win + 1'b1;
                hold_d  = '0;
                state_d = i_req_wr[win] ? OWN_WR : OWN_RD;
            end else begin
                owner_d = '0;
                hold_d  = '0;
                state_d = IDLE;
            end
        end

        grant_rd_d = (state_d == OWN_RD) ? (N_PROC'(1) << owner_d) : '0;
        grant_wr_d = (state_d == OWN_WR) ? (N_PROC'(1) << owner_d) : '0;
    end

    // Memory port: enables from the grants, payload muxed from the owner.
    assign o_busy      = |(o_grant_rd | o_grant_wr);
    assign o_mem_re    = |o_grant_rd;
    assign o_mem_we    = |o_grant_wr;
    assign o_mem_addr  = o_busy ? i_addr[o_owner*ADDR_W +: ADDR_W] : '0;
    assign o_mem_wdata = o_busy ? i_wdata[o_owner*BUS_W +: BUS_W]  : '0;
    assign o_mem_wsize = o_busy ? i_wsize[o_owner*3 +: 3]          : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (MAX_HOLD 2 and 8) driven by the same stimulus
// and compared every cycle against a queue-free behavioural model of the
// round-robin rules.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int BW = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_rd, req_wr;
    logic [N*AW-1:0] addr;
    logic [N*BW-1:0] wdata;
    logic [N*3-1:0]  wsize;

    logic [N-1:0]    grant_rd [2];
    logic [N-1:0]    grant_wr [2];
    logic            mem_re   [2];
    logic            mem_we   [2];
    logic [AW-1:0]   mem_addr [2];
    logic [BW-1:0]   mem_wdata[2];
    logic [2:0]      mem_wsize[2];
    logic [1:0]      owner    [2];
    logic            busy     [2];

    int errors = 0;
    int checks = 0;

    int hold_lim[2] = '{2, 8};
    bit m_busy  [2];
    bit m_wr    [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_n     [2];

    always #5 clk = ~clk;

    mem_arbiter #(.N_PROC(N), .ADDR_W(AW), .BUS_W(BW), .MAX_HOLD(2)) u_h2 (
        .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
        .i_addr(addr), .i_wdata(wdata), .i_wsize(wsize),
        .o_grant_rd(grant_rd[0]), .o_grant_wr(grant_wr[0]),
        .o_mem_re(mem_re[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_wdata(mem_wdata[0]), .o_mem_wsize(mem_wsize[0]),
        .o_owner(owner[0]), .o_busy(busy[0])
    );

    mem_arbiter #(.N_PROC(N), .ADDR_W(AW), .BUS_W(BW), .MAX_HOLD(8)) u_h8 (
        .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
        .i_addr(addr), .i_wdata(wdata), .i_wsize(wsize),
        .o_grant_rd(grant_rd[1]), .o_grant_wr(grant_wr[1]),
        .o_mem_re(mem_re[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_wdata(mem_wdata[1]), .o_mem_wsize(mem_wsize[1]),
        .o_owner(owner[1]), .o_busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] c, input int start);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (start + i) % N;
            if (c[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_wr[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_n[d] = 0;
        end
    endtask

    // Next owner from the current requests; m_n counts granted cycles so far.
    task automatic model_step(input int d);
        logic [N-1:0] req, others, c;
        bit           cur;
        int           k;
        req = req_rd | req_wr;
        c   = req;
        if (m_busy[d]) begin
            cur    = m_wr[d] ? req_wr[m_owner[d]] : req_rd[m_owner[d]];
            others = req;
            others[m_owner[d]] = 1'b0;
            if (cur && (m_n[d] < hold_lim[d] || others == '0)) begin
                m_n[d]++;
                return;
            end
            if (cur) c = others;
        end
        k = pick(c, m_ptr[d]);
        if (k < 0) begin
            m_busy[d] = 0;
            m_n[d]    = 0;
        end else begin
            m_busy[d]  = 1;
            m_owner[d] = k;
            m_wr[d]    = req_wr[k];
            m_ptr[d]   = (k + 1) % N;
            m_n[d]     = 1;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] onehot;
        for (int d = 0; d < 2; d++) begin
            onehot = m_busy[d] ? (N'(1) << m_owner[d]) : '0;
            check($sformatf("grant_rd h%0d", hold_lim[d]), 64'(grant_rd[d]), m_wr[d] ? 64'(0) : 64'(onehot));
            check($sformatf("grant_wr h%0d", hold_lim[d]), 64'(grant_wr[d]), m_wr[d] ? 64'(onehot) : 64'(0));
            check($sformatf("busy h%0d", hold_lim[d]), 64'(busy[d]), 64'(m_busy[d]));
            check($sformatf("mem_re h%0d", hold_lim[d]), 64'(mem_re[d]), 64'(m_busy[d] && !m_wr[d]));
            check($sformatf("mem_we h%0d", hold_lim[d]), 64'(mem_we[d]), 64'(m_busy[d] && m_wr[d]));
            if (m_busy[d]) begin
                check($sformatf("owner h%0d", hold_lim[d]), 64'(owner[d]), 64'(m_owner[d]));
                check($sformatf("mem_addr h%0d", hold_lim[d]), 64'(mem_addr[d]), 64'(addr[m_owner[d]*AW +: AW]));
                check($sformatf("mem_wdata h%0d", hold_lim[d]), 64'(mem_wdata[d]), 64'(wdata[m_owner[d]*BW +: BW]));
                check($sformatf("mem_wsize h%0d", hold_lim[d]), 64'(mem_wsize[d]), 64'(wsize[m_owner[d]*3 +: 3]));
            end else begin
                check($sformatf("idle_port h%0d", hold_lim[d]),
                      64'(mem_addr[d]) | 64'(mem_wdata[d]) | 64'(mem_wsize[d]), 64'(0));
            end
        end
    endtask

    // Called at a negedge: drive, check current outputs, advance model past the edge.
    task automatic step(input logic [N-1:0] rd, input logic [N-1:0] wr);
        req_rd = rd;
        req_wr = wr;
        #1;
        compare_all();
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW]  = $urandom;
            wdata[k*BW +: BW] = $urandom;
            wsize[k*3 +: 3]   = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        int run[2];
        bit done[2];
        int seq[8];
        logic [N-1:0] r_rd, r_wr;

        rstn = 1'b0; req_rd = '0; req_wr = '0;
        rand_data();
        model_reset();
        @(negedge clk); @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset grants", 64'(grant_rd[d] | grant_wr[d]), 64'(0));
            check("reset busy", 64'(busy[d]), 64'(0));
            check("reset owner", 64'(owner[d]), 64'(0));
            check("reset mem_en", 64'({mem_re[d], mem_we[d]}), 64'(0));
        end
        rstn = 1'b1;

        // Round-robin over rd=1011 with MAX_HOLD=2 starting from ptr 0.
        seq = '{0, 0, 1, 1, 3, 3, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step(4'b1011, 4'b0000);
            check($sformatf("rr owner %0d", i), 64'(owner[0]), 64'(seq[i]));
            check($sformatf("rr busy %0d", i), 64'(busy[0]), 64'(1));
        end
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // One-cycle latency, two-cycle read by proc1.
        step(4'b0010, 4'b0000);
        check("lat grant_rd", 64'(grant_rd[1]), 64'(4'b0010));
        check("lat mem_addr", 64'(mem_addr[1]), 64'(addr[1*AW +: AW]));
        step(4'b0010, 4'b0000);
        step(4'b0000, 4'b0000);
        check("lat idle", 64'(busy[1]), 64'(0));

        // Write beats read for the same proc.
        wsize[2*3 +: 3] = 3'd3;
        step(4'b0100, 4'b0100);
        check("prio grant_wr", 64'(grant_wr[1]), 64'(4'b0100));
        check("prio mem_we", 64'(mem_we[1]), 64'(1));
        check("prio wsize", 64'(mem_wsize[1]), 64'(3));
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Preemption: proc0 writes for 20 cycles, proc2 joins from the third.
        run = '{0, 0}; done = '{0, 0};
        for (int i = 0; i < 20; i++) begin
            step(i >= 2 ? 4'b0100 : 4'b0000, 4'b0001);
            for (int d = 0; d < 2; d++) begin
                if (!done[d]) begin
                    if (grant_wr[d] == 4'b0001) run[d]++;
                    else if (run[d] > 0) done[d] = 1;
                end
            end
        end
        check("preempt run h2", 64'(run[0]), 64'(2));
        check("preempt run h8", 64'(run[1]), 64'(8));
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // No competitor: proc0 keeps the grant throughout.
        run = '{0, 0};
        for (int i = 0; i < 20; i++) begin
            step(4'b0000, 4'b0001);
            for (int d = 0; d < 2; d++) if (grant_wr[d] == 4'b0001) run[d]++;
        end
        check("solo run h2", 64'(run[0]), 64'(20));
        check("solo run h8", 64'(run[1]), 64'(20));
        step(4'b0000, 4'b0000);

        // Back-to-back handover from proc0 to proc3.
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0000);
        check("b2b grant0", 64'(grant_rd[1]), 64'(4'b0001));
        step(4'b1000, 4'b0000);
        check("b2b grant3", 64'(grant_rd[1]), 64'(4'b1000));
        check("b2b busy", 64'(busy[1]), 64'(1));
        step(4'b0000, 4'b0000);

        // Asynchronous reset in the middle of a write grant.
        step(4'b0000, 4'b0001);
        step(4'b0000, 4'b0001);
        check("rst pre we", 64'(mem_we[1]), 64'(1));
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst async grants", 64'(grant_rd[d] | grant_wr[d]), 64'(0));
            check("rst async we", 64'(mem_we[d]), 64'(0));
        end
        model_reset();
        req_wr = '0;
        req_rd = 4'b0100;
        @(negedge clk);
        rstn = 1'b1;
        step(4'b0100, 4'b0000);
        check("rst regrant", 64'(grant_rd[1]), 64'(4'b0100));

        // Randomized traffic with sticky requests.
        r_rd = '0; r_wr = '0;
        for (int i = 0; i < 600; i++) begin
            rand_data();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) r_rd[k] = ~r_rd[k];
                if ($urandom_range(0, 5) == 0) r_wr[k] = ~r_wr[k];
            end
            step(r_rd, r_wr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
